// File: rtl/ltc2600_cmd_queue.sv
// Command FIFO and one-at-a-time sequencer in front of the LTC2600 serial writer, with a
// watchdog for unacknowledged frames. Optional shadow readback bank: LTC2600_SHADOW_READBACK_EN.
module ltc2600_cmd_queue #(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [3:0]               push_command,
  input  logic [3:0]               push_address,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     flush,
  output logic                     send_new_cmd,
  output logic [3:0]               command,
  output logic [3:0]               address,
  output logic [DATA_WIDTH-1:0]    data,
  input  logic                     write_complete,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic [2:0]               rd_chan,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam int EW  = 8 + DATA_WIDTH;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [WDW-1:0]  wd_q;
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic            full;
  logic            empty;
  logic            push_accept;
  logic            pop;

  // Handshake: an entry transfers on a rising clk edge where push_valid && push_ready;
  // push_ready depends only on registered pointers, and a flush in that cycle drops the entry.
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign push_ready  = !full;
  assign push_accept = push_valid && !full && !flush;
  assign pop         = (state_q == IDLE) && !empty && !flush;
  assign head        = mem[rd_ptr_q[AW-1:0]];
  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign busy        = (state_q != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[wr_ptr_q[AW-1:0]] <= {push_command, push_address, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)         rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // A watchdog expiry in the same cycle as a flush still latches the error.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      send_new_cmd <= 1'b0;
      command      <= '0;
      address      <= '0;
      data         <= '0;
      wd_q         <= '0;
      timeout_err  <= 1'b0;
    end else begin
      send_new_cmd <= 1'b0;
      if (flush) timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            {command, address, data} <= head;
            send_new_cmd             <= 1'b1;
            wd_q                     <= '0;
            state_q                  <= WAIT;
          end
        end
        WAIT: begin
          if (write_complete) begin
            wd_q    <= '0;
            state_q <= IDLE;
          end else if (wd_q == WD_LAST) begin
            wd_q        <= '0;
            timeout_err <= 1'b1;
            state_q     <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LTC2600_SHADOW_READBACK_EN
  logic [DATA_WIDTH-1:0] shadow_q [8];
  logic                  shadow_we;

  // Only write-and-update commands change the DAC output codes mirrored here.
  assign shadow_we = (state_q == WAIT) && write_complete &&
                     ((command == 4'b0011) || (command == 4'b0010));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
      rd_data <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (shadow_we && ((address == 4'hF) || (address == 4'(i)))) shadow_q[i] <= data;
      end
      rd_data <= shadow_q[rd_chan];
    end
  end
`else
  logic unused_rd_chan;
  assign unused_rd_chan = ^rd_chan;
  assign rd_data        = '0;
`endif

endmodule
